sound_event_scheduler: RTL and testbench
========================================

# sound_event_scheduler

Schedules the game's single tone output among four sound-event requesters: shot, enemy killed, player killed and victory. It latches one-cycle event pulses from the game logic and picks the highest-priority pending event. It then plays that event's fixed note sequence on `sound_key`/`sound_enable` toward the tone decoder, one note per FRAMES_PER_NOTE video frames. It sits between the game-state FSM and the audio tone generator.

## Interface
- FRAMES_PER_NOTE, 4, number of `startOfFrame` pulses each note is held; legal range 1..15.
- GAP_FRAMES, 1, number of `startOfFrame` pulses of silence after a sequence ends; 0 means no gap.
- clk  in  1  system clock; the single clock of the block.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per video frame; the time base.
- shotFired  in  1  request, id 0, lowest priority.
- enemyDead  in  1  request, id 1.
- playerDead  in  1  request, id 2.
- victory  in  1  request, id 3, highest priority.
- sound_key  out  4  tone index to the decoder.
- sound_enable  out  1  tone audible.
- busy  out  1  high in every state except IDLE.
- active_id  out  2  id of the sequence loaded last.

## Operation
- Every request input is sampled each clk. A high sample sets `pend[id]`.
- `pend[id]` is cleared in the LOAD cycle of that id. If a set and a clear of the same bit occur in the same cycle, the set wins and the event plays again afterwards.
- Priority is fixed: 3 > 2 > 1 > 0.
- Sequence ROM (sound_key values, in play order):
  - id 0: 9, 11
  - id 1: 4, 7, 11
  - id 2: 7, 5, 3, 0
  - id 3: 0, 4, 7, 12, 7, 12
- State IDLE:
  - Outputs: enable=0, key=0.
  - Any pend set → LOAD.
- State LOAD (exactly 1 cycle):
  - Latch id = highest-priority pending id into `active_id`.
  - Set note index = 0 and frame counter = 0.
  - Clear `pend[id]`.
  - Any `startOfFrame` in this cycle is ignored.
  - Next state: PLAY.
- State PLAY:
  - Outputs: enable=1, key=ROM[id][idx].
  - Each `startOfFrame` increments the frame counter.
  - On the pulse where counter == FRAMES_PER_NOTE-1, the counter resets to 0, then:
    - if idx is the last note: go to GAP, or to IDLE when GAP_FRAMES = 0;
    - otherwise: idx increments.
- State GAP:
  - Outputs: enable=0, key=0.
  - Counts GAP_FRAMES pulses of `startOfFrame`, then → IDLE.
  - Not preemptible.
- Width rules: the frame counter is 4 bits, the note index is 3 bits. The counter never wraps past FRAMES_PER_NOTE-1.
- Reset mid-sequence: the block returns to IDLE immediately and all pend bits clear.

## Timing
- Reset values:
  - sound_key = 0, sound_enable = 0, busy = 0, active_id = 0.
  - pend = 0, state = IDLE.
- All outputs are registered.
- Request-to-sound latency from IDLE:
  - request sampled at edge N;
  - LOAD at N+1;
  - sound_enable = 1 and the first key valid from edge N+2.
- Note length:
  - first note: the time until the FRAMES_PER_NOTE-th `startOfFrame` after LOAD, i.e. partial first frame;
  - later notes: exactly FRAMES_PER_NOTE frame periods.
- Key changes take effect on the clk edge following the qualifying `startOfFrame` cycle.
- Simultaneous requests: all pend bits are set; they play back to back in priority order, each preceded by its own LOAD.

## Configuration
- SOUND_PREEMPT_EN defined:
  - In PLAY, a `startOfFrame` with a pending id higher than `active_id` aborts the current sequence and goes to LOAD in the next cycle.
  - The aborted event is dropped, not resumed.
  - No GAP is inserted before the new sequence.
- SOUND_PREEMPT_EN undefined:
  - No preemption; every sequence completes before the next LOAD.

## Test plan
All scenarios use FRAMES_PER_NOTE=2 and GAP_FRAMES=1.
- Reset and idle → after reset release with no requests for 10 frames: sound_enable=0, sound_key=0, busy=0, active_id=0 throughout.
- Single shot:
  - stimulus: pulse shotFired in IDLE;
  - response: LOAD one cycle later; keys 9 then 11 with enable=1; enable=0 for 1 frame; busy falls on the edge after the gap's `startOfFrame`.
- Simultaneous requests:
  - stimulus: enemyDead and victory pulsed in the same cycle;
  - response: sequence 0,4,7,12,7,12 with active_id=3, gap, then 4,7,11 with active_id=1.
- Repeat during LOAD:
  - stimulus: shotFired high in the LOAD cycle of id 0;
  - response: the id 0 sequence plays twice.
- Preemption (macro on):
  - stimulus: playerDead during note 2 of the enemy sequence;
  - response: at the next `startOfFrame`, LOAD, then key 7 with active_id=2; enemy notes never resume.
- Preemption (macro off):
  - stimulus: same as the previous scenario;
  - response: 4,7,11 completes, gap, then 7,5,3,0.
- Reset mid-play:
  - stimulus: assert reset during victory note 3 with shotFired pending;
  - response: outputs 0 immediately; nothing plays after release.

Source files
------------

// File: rtl/sound_event_scheduler.sv
// sound_event_scheduler
// Arbitrates the single tone output between four game sound events
// (shot, enemy killed, player killed, victory). One-cycle request pulses are
// latched into pending bits. The highest-priority pending event is loaded,
// and its fixed note sequence is played one note per FRAMES_PER_NOTE video
// frames. An optional silent gap of GAP_FRAMES frames follows each sequence.
//
// Optional feature macro: SOUND_PREEMPT_EN
//   defined   : in PLAY, a frame pulse that sees a pending event of higher
//               priority than the one playing aborts it and loads the new one
//               (the aborted event is dropped, no gap is inserted).
//   undefined : every sequence runs to completion before the next load.
module sound_event_scheduler #(
  parameter int FRAMES_PER_NOTE = 4,
  parameter int GAP_FRAMES      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       shotFired,
  input  logic       enemyDead,
  input  logic       playerDead,
  input  logic       victory,
  output logic [3:0] sound_key,
  output logic       sound_enable,
  output logic       busy,
  output logic [1:0] active_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Last value of the 4-bit frame counter before a note advances.
  localparam logic [3:0] LAST_FRAME = 4'(FRAMES_PER_NOTE - 1);

  // Gap counter is sized to hold GAP_FRAMES-1; at least one bit wide.
  localparam int GAP_W = (GAP_FRAMES > 1) ? $clog2(GAP_FRAMES) : 1;
  localparam logic [GAP_W-1:0] LAST_GAP =
    (GAP_FRAMES > 0) ? GAP_W'(GAP_FRAMES - 1) : '0;

  // Note table: key of note idx within the sequence of event id.
  function automatic logic [3:0] rom_key(input logic [1:0] id, input logic [2:0] idx);
    logic [3:0] k;
    k = 4'd0;
    case (id)
      2'd0: begin
        case (idx)
          3'd0:    k = 4'd9;
          3'd1:    k = 4'd11;
          default: k = 4'd0;
        endcase
      end
      2'd1: begin
        case (idx)
          3'd0:    k = 4'd4;
          3'd1:    k = 4'd7;
          3'd2:    k = 4'd11;
          default: k = 4'd0;
        endcase
      end
      2'd2: begin
        case (idx)
          3'd0:    k = 4'd7;
          3'd1:    k = 4'd5;
          3'd2:    k = 4'd3;
          3'd3:    k = 4'd0;
          default: k = 4'd0;
        endcase
      end
      default: begin
        case (idx)
          3'd0:    k = 4'd0;
          3'd1:    k = 4'd4;
          3'd2:    k = 4'd7;
          3'd3:    k = 4'd12;
          3'd4:    k = 4'd7;
          3'd5:    k = 4'd12;
          default: k = 4'd0;
        endcase
      end
    endcase
    return k;
  endfunction

  // Index of the final note of each sequence.
  function automatic logic [2:0] last_idx(input logic [1:0] id);
    logic [2:0] l;
    case (id)
      2'd0:    l = 3'd1;
      2'd1:    l = 3'd2;
      2'd2:    l = 3'd3;
      default: l = 3'd5;
    endcase
    return l;
  endfunction

  // Fixed priority: id 3 highest, id 0 lowest.
  function automatic logic [1:0] top_id(input logic [3:0] p);
    logic [1:0] t;
    t = 2'd0;
    if (p[3])      t = 2'd3;
    else if (p[2]) t = 2'd2;
    else if (p[1]) t = 2'd1;
    return t;
  endfunction

`ifdef SOUND_PREEMPT_EN
  // True when some pending event outranks the one currently playing.
  function automatic logic higher_pending(input logic [3:0] p, input logic [1:0] id);
    logic h;
    case (id)
      2'd0:    h = |p[3:1];
      2'd1:    h = |p[3:2];
      2'd2:    h = p[3];
      default: h = 1'b0;
    endcase
    return h;
  endfunction
`endif

  state_t           state_reg, state_next;
  logic [3:0]       pend_reg, pend_next;
  logic [3:0]       frame_reg, frame_next;
  logic [2:0]       idx_reg, idx_next;
  logic [GAP_W-1:0] gap_reg, gap_next;
  logic [1:0]       id_reg, id_next;
  logic [3:0]       key_reg, key_next;
  logic             en_reg, en_next;
  logic             busy_reg, busy_next;

  logic [3:0]       req;
  logic [3:0]       clr;
  logic [1:0]       sel_id;

  assign req    = {victory, playerDead, enemyDead, shotFired};
  assign sel_id = top_id(pend_reg);

  // Pending bits: a new request always wins over a same-cycle clear, so an
  // event re-requested during its own LOAD cycle plays again afterwards.
  for (genvar gi = 0; gi < 4; gi++) begin : g_pend
    assign pend_next[gi] = req[gi] | (pend_reg[gi] & ~clr[gi]);
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every output leaves the block straight from a register.
  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    id_next    = id_reg;
    key_next   = key_reg;
    en_next    = en_reg;
    clr        = 4'b0000;

    case (state_reg)
      IDLE: begin
        key_next = 4'd0;
        en_next  = 1'b0;
        if (|pend_reg) begin
          state_next = LOAD;
        end
      end

      // Frame pulses arriving here are deliberately ignored.
      LOAD: begin
        id_next     = sel_id;
        clr[sel_id] = 1'b1;
        idx_next    = 3'd0;
        frame_next  = 4'd0;
        gap_next    = '0;
        key_next    = rom_key(sel_id, 3'd0);
        en_next     = 1'b1;
        state_next  = PLAY;
      end

      PLAY: begin
        if (startOfFrame) begin
`ifdef SOUND_PREEMPT_EN
          if (higher_pending(pend_reg, id_reg)) begin
            state_next = LOAD;
            key_next   = 4'd0;
            en_next    = 1'b0;
          end else
`endif
          if (frame_reg == LAST_FRAME) begin
            frame_next = 4'd0;
            if (idx_reg == last_idx(id_reg)) begin
              key_next   = 4'd0;
              en_next    = 1'b0;
              gap_next   = '0;
              state_next = (GAP_FRAMES == 0) ? IDLE : GAP;
            end else begin
              idx_next = idx_reg + 3'd1;
              key_next = rom_key(id_reg, idx_reg + 3'd1);
            end
          end else begin
            frame_next = frame_reg + 4'd1;
          end
        end
      end

      // Silent gap; requests keep accumulating but cannot cut it short.
      GAP: begin
        key_next = 4'd0;
        en_next  = 1'b0;
        if (startOfFrame) begin
          if (gap_reg == LAST_GAP) begin
            state_next = IDLE;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        key_next   = 4'd0;
        en_next    = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State, pending and output registers; reset silences the block at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pend_reg  <= 4'b0000;
      frame_reg <= 4'd0;
      idx_reg   <= 3'd0;
      gap_reg   <= '0;
      id_reg    <= 2'd0;
      key_reg   <= 4'd0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      frame_reg <= frame_next;
      idx_reg   <= idx_next;
      gap_reg   <= gap_next;
      id_reg    <= id_next;
      key_reg   <= key_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
    end
  end

  assign sound_key    = key_reg;
  assign sound_enable = en_reg;
  assign busy         = busy_reg;
  assign active_id    = id_reg;

endmodule

// File: tb/tb_sound_event_scheduler.sv
// Testbench for sound_event_scheduler (FRAMES_PER_NOTE=2, GAP_FRAMES=1).
// A queue-based reference model of the scheduler's rules is stepped on every
// clock, and the DUT outputs are compared against it on every falling edge.
// Directed scenarios additionally pin the played note log and the reset and
// latency behaviour to hand-written literal values.
module tb_sound_event_scheduler;
  localparam int FPN = 2;
  localparam int GAP = 1;
`ifdef SOUND_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_PLAY = 2;
  localparam int P_GAP  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       shotFired = 1'b0;
  logic       enemyDead = 1'b0;
  logic       playerDead = 1'b0;
  logic       victory = 1'b0;
  logic [3:0] sound_key;
  logic       sound_enable;
  logic       busy;
  logic [1:0] active_id;

  int checks = 0;
  int failures = 0;

  sound_event_scheduler #(
    .FRAMES_PER_NOTE(FPN),
    .GAP_FRAMES(GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startOfFrame(startOfFrame),
    .shotFired(shotFired),
    .enemyDead(enemyDead),
    .playerDead(playerDead),
    .victory(victory),
    .sound_key(sound_key),
    .sound_enable(sound_enable),
    .busy(busy),
    .active_id(active_id)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int       m_phase = P_IDLE;
  bit [3:0] m_pend = 4'b0;
  int       m_id = 0;
  int       m_notes[$];
  int       m_frames_left = 0;
  int       m_gap_left = 0;

  function automatic int top_pending(bit [3:0] p);
    for (int i = 3; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_pend = 4'b0;
    m_id = 0;
    m_notes.delete();
    m_frames_left = 0;
    m_gap_left = 0;
  endtask

  task automatic model_step();
    bit [3:0] req;
    bit [3:0] clr;
    int top;
    req = {victory, playerDead, enemyDead, shotFired};
    clr = 4'b0;
    top = top_pending(m_pend);
    case (m_phase)
      P_IDLE: if (m_pend != 0) m_phase = P_LOAD;
      P_LOAD: begin
        if (top >= 0) begin
          m_id = top;
          clr[top] = 1'b1;
          m_notes.delete();
          case (top)
            0: begin m_notes.push_back(9); m_notes.push_back(11); end
            1: begin m_notes.push_back(4); m_notes.push_back(7); m_notes.push_back(11); end
            2: begin m_notes.push_back(7); m_notes.push_back(5); m_notes.push_back(3); m_notes.push_back(0); end
            default: begin
              m_notes.push_back(0); m_notes.push_back(4); m_notes.push_back(7);
              m_notes.push_back(12); m_notes.push_back(7); m_notes.push_back(12);
            end
          endcase
          m_frames_left = FPN;
        end
        m_phase = P_PLAY;
      end
      P_PLAY: if (startOfFrame) begin
        if (PREEMPT && top > m_id) begin
          m_notes.delete();
          m_phase = P_LOAD;
        end else begin
          m_frames_left--;
          if (m_frames_left == 0) begin
            void'(m_notes.pop_front());
            if (m_notes.size() == 0) begin
              m_phase = (GAP > 0) ? P_GAP : P_IDLE;
              m_gap_left = GAP;
            end else begin
              m_frames_left = FPN;
            end
          end
        end
      end
      P_GAP: if (startOfFrame) begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = P_IDLE;
      end
      default: m_phase = P_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | req;
  endtask

  // Model advances on the same edges as the DUT registers.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  // ---------------- per-cycle compare and note log ----------------
  int         log_q[$];
  logic       prev_en = 1'b0;
  logic [3:0] prev_key = 4'd0;
  logic [1:0] prev_id = 2'd0;
  int         cyc_no = 0;

  initial forever begin
    int exp_key;
    int exp_en;
    int exp_busy;
    int exp_id;
    @(negedge clk);
    cyc_no++;
    exp_busy = (m_phase != P_IDLE) ? 1 : 0;
    exp_en   = (m_phase == P_PLAY) ? 1 : 0;
    exp_key  = (exp_en == 1 && m_notes.size() > 0) ? m_notes[0] : 0;
    exp_id   = m_id;
    checks++;
    if (sound_key !== 4'(exp_key) || sound_enable !== exp_en[0] ||
        busy !== exp_busy[0] || active_id !== 2'(exp_id)) begin
      failures++;
      $display("FAIL cycle %0d outputs: key=%0d en=%0d busy=%0d id=%0d required key=%0d en=%0d busy=%0d id=%0d",
               cyc_no, sound_key, sound_enable, busy, active_id, exp_key, exp_en, exp_busy, exp_id);
    end
    if (sound_enable === 1'b1 && (!prev_en || sound_key != prev_key || active_id != prev_id))
      log_q.push_back(int'(active_id) * 16 + int'(sound_key));
    prev_en  = sound_enable;
    prev_key = sound_key;
    prev_id  = active_id;
  end

  // ---------------- stimulus helpers ----------------
  bit rand_sof = 1'b0;
  int sof_cnt = 0;

  // Hold request vector r for one cycle; returns 1 time unit after the next
  // falling edge so that the compare process has already run.
  task automatic drive(bit [3:0] r);
    {victory, playerDead, enemyDead, shotFired} = r;
    startOfFrame = rand_sof ? ($urandom_range(0, 2) == 0) : ((sof_cnt % 4) == 0);
    sof_cnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic check_val(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_log(string name, int exp[$]);
    bit bad;
    string sa;
    string se;
    bad = (log_q.size() != exp.size());
    if (!bad) foreach (exp[i]) if (log_q[i] != exp[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      failures++;
      sa = "";
      se = "";
      foreach (log_q[i]) sa = $sformatf("%s %0d:%0d", sa, log_q[i] / 16, log_q[i] % 16);
      foreach (exp[i]) se = $sformatf("%s %0d:%0d", se, exp[i] / 16, exp[i] % 16);
      $display("FAIL %s note log (id:key): actual [%s ] required [%s ]", name, sa, se);
    end
  endtask

  task automatic wait_idle(string name, int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy == 1'b0 && m_pend == 4'b0) return;
      drive(4'b0);
    end
    checks++;
    failures++;
    $display("FAIL %s: wait for idle timed out, actual busy=%0d required busy=0", name, busy);
  endtask

  task automatic wait_key(string name, int key, int id, int budget);
    for (int i = 0; i < budget; i++) begin
      if (sound_enable == 1'b1 && int'(sound_key) == key && int'(active_id) == id) return;
      drive(4'b0);
    end
    checks++;
    failures++;
    $display("FAIL %s: wait for key timed out, actual key=%0d id=%0d required key=%0d id=%0d",
             name, sound_key, active_id, key, id);
  endtask

  task automatic pulse_reset();
    {victory, playerDead, enemyDead, shotFired} = 4'b0;
    startOfFrame = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int e[$];
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    check_val("reset sound_key", int'(sound_key), 0);
    check_val("reset sound_enable", int'(sound_enable), 0);
    check_val("reset busy", int'(busy), 0);
    check_val("reset active_id", int'(active_id), 0);

    // Idle for 10 frames.
    log_q.delete();
    repeat (40) drive(4'b0);
    check_val("idle busy", int'(busy), 0);
    e = '{};
    check_log("idle", e);

    // Single shot with latency checks.
    log_q.delete();
    drive(4'b0001);
    check_val("shot edge N busy", int'(busy), 0);
    drive(4'b0);
    check_val("shot LOAD busy", int'(busy), 1);
    check_val("shot LOAD enable", int'(sound_enable), 0);
    drive(4'b0);
    check_val("shot first enable", int'(sound_enable), 1);
    check_val("shot first key", int'(sound_key), 9);
    check_val("shot active_id", int'(active_id), 0);
    wait_idle("shot", 200);
    e = '{9, 11};
    check_log("shot", e);

    // Simultaneous enemyDead + victory.
    log_q.delete();
    drive(4'b1010);
    wait_idle("simultaneous", 400);
    e = '{48, 52, 55, 60, 55, 60, 20, 23, 27};
    check_log("simultaneous", e);

    // Repeat request during the LOAD cycle of id 0.
    log_q.delete();
    drive(4'b0001);
    drive(4'b0);
    drive(4'b0001);
    wait_idle("repeat", 300);
    e = '{9, 11, 9, 11};
    check_log("repeat in LOAD", e);

    // playerDead during note 2 of the enemy sequence.
    log_q.delete();
    drive(4'b0010);
    wait_key("preempt setup", 7, 1, 100);
    drive(4'b0100);
    wait_idle("preempt", 400);
    if (PREEMPT) e = '{20, 23, 39, 37, 35, 32};
    else e = '{20, 23, 27, 39, 37, 35, 32};
    check_log("preemption", e);

    // Reset during victory note 3 with a shot pending.
    drive(4'b1000);
    wait_key("reset setup", 7, 3, 100);
    drive(4'b0001);
    drive(4'b0);
    reset = 1'b1;
    #1;
    check_val("midreset sound_key", int'(sound_key), 0);
    check_val("midreset sound_enable", int'(sound_enable), 0);
    check_val("midreset busy", int'(busy), 0);
    check_val("midreset active_id", int'(active_id), 0);
    @(negedge clk);
    #1;
    log_q.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    repeat (40) drive(4'b0);
    check_val("after reset busy", int'(busy), 0);
    e = '{};
    check_log("after reset", e);

    // Randomized traffic with random frame pulses and occasional resets.
    rand_sof = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit [3:0] r;
      for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 799) == 0) pulse_reset();
      else drive(r);
    end
    rand_sof = 1'b0;
    wait_idle("random drain", 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
